// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared constants and types for the fetch front end
// Contents: ADDR_W, RESET_PC, INSTR_W, NOP_INSTR, qentry_t {instr, pc}
package fetch_sequencer_pkg;

    localparam int ADDR_W   = 10;
    localparam int RESET_PC = 0;
    localparam int INSTR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } qentry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory, redirect and decode signals of the fetch front end
// master: the sequencer (drives imem_addr_o/imem_stall_o, inst*/pc*/valid_o)
// slave : memory + redirect source + decode (drives imem_data_i, redirect_*, dec_ready_i)
interface fetch_sequencer_if #(
    parameter int ADDR_W = fetch_sequencer_pkg::ADDR_W
);
    import fetch_sequencer_pkg::*;

    logic [ADDR_W-1:0]    imem_addr_o;
    logic                 imem_stall_o;
    logic [2*INSTR_W-1:0] imem_data_i;
    logic                 redirect_i;
    logic [ADDR_W-1:0]    redirect_pc_i;
    logic [1:0]           dec_ready_i;
    logic [INSTR_W-1:0]   inst0_o;
    logic [INSTR_W-1:0]   inst1_o;
    logic [ADDR_W-1:0]    pc0_o;
    logic [ADDR_W-1:0]    pc1_o;
    logic [1:0]           valid_o;

    modport master (
        output imem_addr_o, imem_stall_o, inst0_o, inst1_o, pc0_o, pc1_o, valid_o,
        input  imem_data_i, redirect_i, redirect_pc_i, dec_ready_i
    );

    modport slave (
        input  imem_addr_o, imem_stall_o, inst0_o, inst1_o, pc0_o, pc1_o, valid_o,
        output imem_data_i, redirect_i, redirect_pc_i, dec_ready_i
    );

endinterface

// File: rtl/fetch_sequencer_queue.sv
// rtl/fetch_sequencer_queue.sv - instruction queue: 2-wide push, 0..2 pop, flush
// Ports: clock_i, reset_i, flush, push, push_data (pair), push_pc (PC of low word),
//        pop (0..2), head0/head1 instr+pc, count
module fetch_queue
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         flush,
    input  logic                         push,
    input  logic [2*INSTR_W-1:0]         push_data,
    input  logic [AW-1:0]                push_pc,
    input  logic [1:0]                   pop,
    output logic [INSTR_W-1:0]           head0_instr,
    output logic [AW-1:0]                head0_pc,
    output logic [INSTR_W-1:0]           head1_instr,
    output logic [AW-1:0]                head1_pc,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      pc_mem    [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    // Storage needs no reset; only pointers and count define what is live.
    always_ff @(posedge clock_i) begin
        if (push) begin
            instr_mem[wr_ptr]          <= push_data[INSTR_W-1:0];
            instr_mem[wr_ptr + PW'(1)] <= push_data[2*INSTR_W-1:INSTR_W];
            pc_mem[wr_ptr]             <= push_pc;
            pc_mem[wr_ptr + PW'(1)]    <= push_pc + AW'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(2);
            end
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (push ? CW'(2) : CW'(0)) - CW'(pop);
        end
    end

    assign head0_instr = instr_mem[rd_ptr];
    assign head0_pc    = pc_mem[rd_ptr];
    assign head1_instr = instr_mem[rd_ptr + PW'(1)];
    assign head1_pc    = pc_mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC, issue and in-flight tracking for dual-word imem
// Ports: clock_i, reset_i (sync, active high), bus (fetch_sequencer_if.master):
//        imem_addr_o/imem_stall_o/imem_data_i, redirect_i/redirect_pc_i,
//        dec_ready_i, inst0_o/inst1_o/pc0_o/pc1_o/valid_o
module fetch_sequencer #(
    parameter int ADDR_W   = fetch_sequencer_pkg::ADDR_W,
    parameter int RESET_PC = fetch_sequencer_pkg::RESET_PC,
    parameter int QDEPTH   = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    fetch_sequencer_if.master   bus
);
    import fetch_sequencer_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int NW = CW + 1;
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;

    logic [CW-1:0]      count;
    logic [NW-1:0]      count_next;
    logic [1:0]         dec_sat;
    logic [1:0]         pop;
    logic               push;
    logic               issue;

    logic [INSTR_W-1:0] head0_instr;
    logic [INSTR_W-1:0] head1_instr;
    logic [ADDR_W-1:0]  head0_pc;
    logic [ADDR_W-1:0]  head1_pc;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .AW    (ADDR_W)
    ) u_queue (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .flush       (bus.redirect_i),
        .push        (push),
        .push_data   (bus.imem_data_i),
        .push_pc     (inflight_pc),
        .pop         (pop),
        .head0_instr (head0_instr),
        .head0_pc    (head0_pc),
        .head1_instr (head1_instr),
        .head1_pc    (head1_pc),
        .count       (count)
    );

    // Issue only if the pair coming back next cycle is guaranteed a slot.
    always_comb begin
        dec_sat = (bus.dec_ready_i == 2'd3) ? 2'd2 : bus.dec_ready_i;
        pop     = 2'd0;
        if (!bus.redirect_i) begin
            pop = (count >= CW'(dec_sat)) ? dec_sat : count[1:0];
        end
        push       = inflight && !bus.redirect_i;
        count_next = NW'(count) + (push ? NW'(2) : NW'(0)) - NW'(pop);
        issue      = bus.redirect_i || (count_next <= NW'(QDEPTH - 2));
    end

    always_comb begin
        bus.imem_addr_o  = fetch_pc;
        bus.imem_stall_o = !issue;
        bus.valid_o      = {count >= CW'(2), count != '0};
        if (reset_i) begin
            bus.imem_addr_o  = START_PC;
            bus.imem_stall_o = 1'b1;
            bus.valid_o      = 2'b00;
        end else if (bus.redirect_i) begin
            bus.imem_addr_o  = bus.redirect_pc_i;
            bus.imem_stall_o = 1'b0;
            bus.valid_o      = 2'b00;
        end
        bus.inst0_o = bus.valid_o[0] ? head0_instr : NOP_INSTR;
        bus.inst1_o = bus.valid_o[1] ? head1_instr : NOP_INSTR;
        bus.pc0_o   = head0_pc;
        bus.pc1_o   = head1_pc;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fetch_pc    <= START_PC;
            inflight_pc <= START_PC;
            inflight    <= 1'b0;
        end else if (bus.redirect_i) begin
            fetch_pc    <= bus.redirect_pc_i + PC_STEP;
            inflight_pc <= bus.redirect_pc_i;
            inflight    <= 1'b1;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + PC_STEP;
            inflight_pc <= fetch_pc;
            inflight    <= 1'b1;
        end else begin
            inflight    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int AW     = 10;
    localparam int QDEPTH = 4;
    localparam int RPC    = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_sequencer_if #(.ADDR_W(AW)) bus ();

    fetch_sequencer #(
        .ADDR_W   (AW),
        .RESET_PC (RPC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: registered address, pair read back one cycle later.
    logic [31:0]   mem [1024];
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_p1;

    always @(posedge clk) begin
        if (!bus.imem_stall_o) rd_addr <= bus.imem_addr_o;
    end
    assign rd_addr_p1      = rd_addr + 10'd1;
    assign bus.imem_data_i = {mem[rd_addr_p1], mem[rd_addr]};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state kept as plain values and a queue.
    logic [AW-1:0] m_fpc;
    logic [AW-1:0] m_ipc;
    bit            m_infl;
    qentry_t       mq[$];

    // Last sampled outputs, for directed checks.
    logic [AW-1:0] s_addr, s_pc0, s_pc1;
    logic [31:0]   s_inst0, s_inst1;
    logic [1:0]    s_valid;
    logic          s_stall;

    task automatic cycle(input bit r, input bit rd, input logic [AW-1:0] rpc, input logic [1:0] dr);
        int      sat, size, npop, cn;
        bit      push, issue;
        logic [1:0]    e_valid;
        logic [AW-1:0] p1;
        qentry_t       e;
        @(negedge clk);
        rst               = r;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.dec_ready_i   = dr;
        #1;
        s_addr  = bus.imem_addr_o;
        s_stall = bus.imem_stall_o;
        s_valid = bus.valid_o;
        s_pc0   = bus.pc0_o;
        s_pc1   = bus.pc1_o;
        s_inst0 = bus.inst0_o;
        s_inst1 = bus.inst1_o;

        size  = mq.size();
        sat   = (dr > 2) ? 2 : int'(dr);
        npop  = rd ? 0 : ((sat < size) ? sat : size);
        push  = m_infl && !rd;
        cn    = size + (push ? 2 : 0) - npop;
        issue = rd || (cn <= QDEPTH - 2);

        if (r) begin
            check_eq("rst_valid", s_valid, 2'b00);
            check_eq("rst_stall", s_stall, 1'b1);
            check_eq("rst_addr", s_addr, RPC);
        end else begin
            check_eq("addr", s_addr, rd ? rpc : m_fpc);
            check_eq("stall", s_stall, !issue);
            e_valid = rd ? 2'b00 : {size >= 2, size >= 1};
            check_eq("valid", s_valid, e_valid);
            check_eq("inst0", s_inst0, e_valid[0] ? mq[0].instr : NOP_INSTR);
            check_eq("inst1", s_inst1, e_valid[1] ? mq[1].instr : NOP_INSTR);
            if (e_valid[0]) check_eq("pc0", s_pc0, mq[0].pc);
            if (e_valid[1]) check_eq("pc1", s_pc1, mq[1].pc);
        end

        @(posedge clk);
        if (r) begin
            m_fpc  = AW'(RPC);
            m_ipc  = AW'(RPC);
            m_infl = 1'b0;
            mq.delete();
        end else begin
            if (rd) begin
                mq.delete();
            end else begin
                repeat (npop) void'(mq.pop_front());
                if (push) begin
                    p1 = m_ipc + 10'd1;
                    e.instr = mem[m_ipc]; e.pc = m_ipc; mq.push_back(e);
                    e.instr = mem[p1];    e.pc = p1;    mq.push_back(e);
                end
            end
            if (rd) begin
                m_fpc  = rpc + 10'd2;
                m_ipc  = rpc;
                m_infl = 1'b1;
            end else if (issue) begin
                m_ipc  = m_fpc;
                m_fpc  = m_fpc + 10'd2;
                m_infl = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    initial begin
        logic [AW-1:0] a1023;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.dec_ready_i   = 2'd2;
        m_fpc = '0; m_ipc = '0; m_infl = 1'b0;

        repeat (3) cycle(1, 0, 0, 2);

        // Streaming from reset
        cycle(0, 0, 0, 2);
        check_eq("first_addr", s_addr, 0);
        cycle(0, 0, 0, 2);
        check_eq("second_addr", s_addr, 2);
        cycle(0, 0, 0, 2);
        check_eq("first_valid", s_valid, 2'b11);
        check_eq("first_inst0", s_inst0, mem[0]);
        check_eq("first_inst1", s_inst1, mem[1]);
        repeat (10) cycle(0, 0, 0, 2);

        // Decode stalled: queue fills, memory stalls
        repeat (10) cycle(0, 0, 0, 0);
        check_eq("full_stall", s_stall, 1'b1);
        check_eq("full_valid", s_valid, 2'b11);
        repeat (8) cycle(0, 0, 0, 1);

        // Redirect to 7 with a read in flight
        repeat (6) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 2);
        cycle(0, 1, 7, 0);
        check_eq("redir7_n", s_valid, 2'b00);
        cycle(0, 0, 0, 0);
        check_eq("redir7_n1", s_valid, 2'b00);
        cycle(0, 0, 0, 0);
        check_eq("redir7_valid", s_valid, 2'b11);
        check_eq("redir7_pc0", s_pc0, 7);
        check_eq("redir7_pc1", s_pc1, 8);
        check_eq("redir7_inst0", s_inst0, mem[7]);

        // Redirect to the top of the address space
        a1023 = 10'd1023;
        cycle(0, 1, a1023, 0);
        cycle(0, 0, 0, 0);
        check_eq("wrap_next_addr", s_addr, 1);
        cycle(0, 0, 0, 2);
        check_eq("wrap_pc0", s_pc0, 1023);
        check_eq("wrap_pc1", s_pc1, 0);
        check_eq("wrap_inst1", s_inst1, mem[0]);

        // dec_ready 3 acts as 2
        repeat (8) cycle(0, 0, 0, 3);

        // Reset coincident with redirect
        cycle(1, 1, 77, 2);
        cycle(0, 0, 0, 2);
        check_eq("rst_redir_valid", s_valid, 2'b00);
        check_eq("rst_redir_addr", s_addr, RPC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 15) == 0),
                  AW'($urandom),
                  2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
